// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding, counter width and reset vector for the pipeline sequencer
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } pctl_state_e;
  localparam int FLUSH_CNT_WIDTH = 3;
  localparam logic [31:0] RST_INST_ADDR = 32'h0;
endpackage

// File: rtl/pctl_flush_cnt.sv
// pctl_flush_cnt: loadable down-counter that stops at zero, with a nonzero flag
module pctl_flush_cnt
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [FLUSH_CNT_WIDTH-1:0] INIT = 3'd2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  output logic [FLUSH_CNT_WIDTH-1:0] cnt,
  output logic                       nz
);
  assign nz = |cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= INIT;
    else cnt <= load ? INIT : cnt - FLUSH_CNT_WIDTH'(nz);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: PC redirect, hold and flush sequencer for the IF, IF/ID and ID/EX stages
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    FLUSH_CYCLES = 2,
  parameter logic [ADDR_WIDTH-1:0] RST_ADDR     = ADDR_WIDTH'(RST_INST_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_req_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  trap_req_i,
  input  logic [ADDR_WIDTH-1:0] trap_addr_i,
  input  logic                  div_busy_i,
  input  logic                  load_use_i,
  input  logic                  halt_req_i,
  output logic                  pc_hold_o,
  output logic                  if_id_hold_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_addr_o,
  output logic                  halted_o
);
  pctl_state_e state, state_nxt, prog;
  logic trap_pend, first, eff_trap, take_trap, take_jump, redirect, cnt_nz;
  logic [ADDR_WIDTH-1:0] trap_addr_q;
  logic [FLUSH_CNT_WIDTH-1:0] cnt;
  assign eff_trap  = trap_req_i || trap_pend;
  assign take_trap = eff_trap && !div_busy_i && state != S_HALT;
  assign take_jump = !take_trap && jump_req_i && !div_busy_i;
  assign redirect  = take_trap || take_jump;
  assign redirect_o      = !rst && redirect;
  assign redirect_addr_o = rst ? RST_ADDR : take_trap ? (trap_pend ? trap_addr_q : trap_addr_i) : jump_addr_i;
  assign pc_hold_o       = !rst && !redirect && (div_busy_i || load_use_i || state == S_HALT);
  assign if_id_hold_o    = pc_hold_o;
  assign if_id_flush_o   = state == S_FLUSH && cnt_nz;
  assign id_ex_flush_o   = rst || (!div_busy_i && ((state == S_FLUSH && first) ||
                           (!redirect && (load_use_i || state == S_HALT))));
  assign halted_o        = state == S_HALT;
  pctl_flush_cnt #(.INIT(FLUSH_CNT_WIDTH'(FLUSH_CYCLES))) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (redirect),
    .cnt  (cnt),
    .nz   (cnt_nz)
  );
  always_comb begin
    prog      = state == S_FLUSH ? (cnt > FLUSH_CNT_WIDTH'(1) ? S_FLUSH : S_RUN) :
                state == S_HALT && halt_req_i ? S_HALT : S_RUN;
    state_nxt = redirect ? S_FLUSH : div_busy_i ? S_STALL :
                !load_use_i && halt_req_i && state == S_RUN ? S_HALT : prog;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= S_FLUSH;
      first       <= 1'b1;
      trap_pend   <= 1'b0;
      trap_addr_q <= RST_ADDR;
    end else begin
      state     <= state_nxt;
      first     <= redirect;
      trap_pend <= eff_trap && !take_trap;
      if (trap_req_i && !take_trap) trap_addr_q <= trap_addr_i;
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic rst;
  logic jump_req_i, trap_req_i, div_busy_i, load_use_i, halt_req_i;
  logic [31:0] jump_addr_i, trap_addr_i;
  logic pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_flush_o, redirect_o, halted_o;
  logic [31:0] redirect_addr_o;
  int checks = 0;
  int errors = 0;
  int m_flush;
  bit m_bubble, m_halted, m_stalled, m_pend;
  logic [31:0] m_pend_addr;
  always #5 clk = ~clk;
  pipeline_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(FC), .RST_ADDR(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_req_i      (jump_req_i),
    .jump_addr_i     (jump_addr_i),
    .trap_req_i      (trap_req_i),
    .trap_addr_i     (trap_addr_i),
    .div_busy_i      (div_busy_i),
    .load_use_i      (load_use_i),
    .halt_req_i      (halt_req_i),
    .pc_hold_o       (pc_hold_o),
    .if_id_hold_o    (if_id_hold_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .redirect_o      (redirect_o),
    .redirect_addr_o (redirect_addr_o),
    .halted_o        (halted_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle();
    jump_req_i = 1'b0;
    trap_req_i = 1'b0;
    div_busy_i = 1'b0;
    load_use_i = 1'b0;
    halt_req_i = 1'b0;
    jump_addr_i = 32'h0000_0abc;
    trap_addr_i = 32'h0000_0def;
  endtask
  task automatic tick();
    bit eff, tt, tj, rd, run, nh;
    logic [31:0] exp_addr;
    @(negedge clk);
    if (rst) begin
      check("rst_pc_hold", pc_hold_o, 1'b0);
      check("rst_if_id_hold", if_id_hold_o, 1'b0);
      check("rst_redirect", redirect_o, 1'b0);
      check("rst_addr", redirect_addr_o, 32'h0);
      check("rst_if_id_flush", if_id_flush_o, 1'b1);
      check("rst_id_ex_flush", id_ex_flush_o, 1'b1);
      check("rst_halted", halted_o, 1'b0);
      m_flush = FC;
      m_bubble = 1'b1;
      m_halted = 1'b0;
      m_stalled = 1'b0;
      m_pend = 1'b0;
    end else begin
      eff = trap_req_i || m_pend;
      tt = eff && !div_busy_i && !m_halted;
      tj = !tt && jump_req_i && !div_busy_i;
      rd = tt || tj;
      exp_addr = tt ? (m_pend ? m_pend_addr : trap_addr_i) : jump_addr_i;
      check("m_redirect", redirect_o, rd);
      if (rd) check("m_addr", redirect_addr_o, exp_addr);
      check("m_pc_hold", pc_hold_o, !rd && (div_busy_i || load_use_i || m_halted));
      check("m_if_id_hold", if_id_hold_o, !rd && (div_busy_i || load_use_i || m_halted));
      check("m_if_id_flush", if_id_flush_o, m_flush != 0);
      check("m_id_ex_flush", id_ex_flush_o, !div_busy_i && (m_bubble || (!rd && (load_use_i || m_halted))));
      check("m_halted", halted_o, m_halted);
      run = !m_halted && m_flush == 0 && !m_stalled;
      nh = (rd || div_busy_i) ? 1'b0 : load_use_i ? (m_halted && halt_req_i) : (halt_req_i && (m_halted || run));
      if (trap_req_i && !tt) m_pend_addr = trap_addr_i;
      m_pend = eff && !tt;
      m_flush = rd ? FC : div_busy_i ? 0 : (m_flush > 0 ? m_flush - 1 : 0);
      m_bubble = rd;
      m_stalled = div_busy_i;
      m_halted = nh;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    idle();
    jump_req_i = 1'b1;
    div_busy_i = 1'b1;
    jump_addr_i = 32'h80;
    #1;
    tick();
    tick();
    rst = 1'b0;
    idle();
    #1 check("t1_flush_c0", if_id_flush_o, 1'b1);
    tick();
    #1 check("t1_flush_c1", if_id_flush_o, 1'b1);
    tick();
    #1 check("t1_flush_c2", if_id_flush_o, 1'b0);
    check("t1_no_hold", pc_hold_o, 1'b0);
    tick();
    jump_req_i = 1'b1;
    jump_addr_i = 32'h80;
    #1 check("t2_redirect", redirect_o, 1'b1);
    check("t2_addr", redirect_addr_o, 32'h80);
    tick();
    idle();
    #1 check("t2_if_id_c1", if_id_flush_o, 1'b1);
    check("t2_id_ex_c1", id_ex_flush_o, 1'b1);
    tick();
    #1 check("t2_if_id_c2", if_id_flush_o, 1'b1);
    check("t2_id_ex_c2", id_ex_flush_o, 1'b0);
    tick();
    #1 check("t2_if_id_c3", if_id_flush_o, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      div_busy_i = 1'b1;
      trap_req_i = i == 2;
      trap_addr_i = i == 2 ? 32'h100 : 32'h554;
      #1 check("t3_hold", pc_hold_o, 1'b1);
      check("t3_no_redirect", redirect_o, 1'b0);
      tick();
    end
    idle();
    trap_addr_i = 32'h554;
    #1 check("t3_redirect", redirect_o, 1'b1);
    check("t3_addr", redirect_addr_o, 32'h100);
    tick();
    idle();
    repeat (3) tick();
    trap_req_i = 1'b1;
    trap_addr_i = 32'h100;
    jump_req_i = 1'b1;
    jump_addr_i = 32'h80;
    #1 check("t4_addr", redirect_addr_o, 32'h100);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_jump_dropped", redirect_o, 1'b0);
      tick();
    end
    load_use_i = 1'b1;
    #1 check("t5_pc_hold", pc_hold_o, 1'b1);
    check("t5_if_id_hold", if_id_hold_o, 1'b1);
    check("t5_id_ex", id_ex_flush_o, 1'b1);
    tick();
    idle();
    #1 check("t5_hold_off", pc_hold_o, 1'b0);
    check("t5_id_ex_off", id_ex_flush_o, 1'b0);
    tick();
    jump_req_i = 1'b1;
    jump_addr_i = 32'h80;
    tick();
    jump_addr_i = 32'h200;
    #1 check("t6_redirect2", redirect_o, 1'b1);
    check("t6_addr2", redirect_addr_o, 32'h200);
    tick();
    idle();
    #1 check("t6_flush_t2", if_id_flush_o, 1'b1);
    tick();
    #1 check("t6_flush_t3", if_id_flush_o, 1'b1);
    tick();
    #1 check("t6_flush_t4", if_id_flush_o, 1'b0);
    tick();
    halt_req_i = 1'b1;
    #1 check("t7_halted_h0", halted_o, 1'b0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      halt_req_i = i < 3;
      #1 check("t7_halted", halted_o, 1'b1);
      check("t7_pc_hold", pc_hold_o, 1'b1);
      tick();
    end
    idle();
    #1 check("t7_resumed", halted_o, 1'b0);
    check("t7_hold_off", pc_hold_o, 1'b0);
    tick();
    div_busy_i = 1'b1;
    trap_req_i = 1'b1;
    trap_addr_i = 32'h100;
    tick();
    trap_req_i = 1'b0;
    jump_addr_i = 32'h80;
    #1 check("t8_mid_stall", pc_hold_o, 1'b1);
    rst = 1'b1;
    #1 check("t8_async_hold", pc_hold_o, 1'b0);
    check("t8_async_if_id_hold", if_id_hold_o, 1'b0);
    check("t8_async_if_id", if_id_flush_o, 1'b1);
    check("t8_async_id_ex", id_ex_flush_o, 1'b1);
    check("t8_async_redirect", redirect_o, 1'b0);
    check("t8_async_addr", redirect_addr_o, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    #1 check("t8_pend_cleared", redirect_o, 1'b0);
    tick();
    repeat (3) tick();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(99) == 0;
      jump_req_i = $urandom_range(99) < 15;
      jump_addr_i = $urandom & 32'hffff_fffc;
      trap_req_i = $urandom_range(99) < 10;
      trap_addr_i = $urandom & 32'hffff_fffc;
      load_use_i = $urandom_range(99) < 15;
      if ($urandom_range(99) < 25) div_busy_i = !div_busy_i;
      if ($urandom_range(99) < 15) halt_req_i = !halt_req_i;
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
